// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the instruction memory read
// address, captures synchronous-read data and presents it to decode over a
// valid/ready handshake. A single-entry skid buffer absorbs the word that is
// already in flight when decode stalls.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not fetching; waits for a start pulse
// FETCH | issuing reads, returning words, honouring branch and halt

`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 10
`endif
`ifndef INST_LENGTH
`define INST_LENGTH 32
`endif

module inst_fetch_ctrl #(
    parameter int                ADDR_W   = `INSTMEM_ADDR_WIDTH,
    parameter int                INST_W   = `INST_LENGTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              halt,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_q,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;

    // A read issued last cycle; its data is on mem_q this cycle.
    logic              inflight, inflight_nxt;
    logic [ADDR_W-1:0] inflight_pc, inflight_pc_nxt;

    logic              skid_valid, skid_valid_nxt;
    logic [INST_W-1:0] skid_inst, skid_inst_nxt;
    logic [ADDR_W-1:0] skid_pc, skid_pc_nxt;

    logic              inst_valid_nxt;
    logic [INST_W-1:0] inst_nxt;
    logic [ADDR_W-1:0] inst_pc_nxt;

    logic              issue_en;
    logic              out_free;

    assign mem_addr = pc;
    assign busy     = (state != IDLE);

    // The output register can take a new word when empty or accepted this edge.
    assign out_free = !inst_valid || inst_ready;

    // State and datapath registers; everything is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            skid_valid  <= 1'b0;
            skid_inst   <= '0;
            skid_pc     <= '0;
            inst_valid  <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inflight    <= inflight_nxt;
            inflight_pc <= inflight_pc_nxt;
            skid_valid  <= skid_valid_nxt;
            skid_inst   <= skid_inst_nxt;
            skid_pc     <= skid_pc_nxt;
            inst_valid  <= inst_valid_nxt;
            inst        <= inst_nxt;
            inst_pc     <= inst_pc_nxt;
        end
    end

    // Next-state, issue decision and return-path steering.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        inflight_nxt    = 1'b0;
        inflight_pc_nxt = inflight_pc;
        skid_valid_nxt  = skid_valid;
        skid_inst_nxt   = skid_inst;
        skid_pc_nxt     = skid_pc;
        inst_valid_nxt  = inst_valid;
        inst_nxt        = inst;
        inst_pc_nxt     = inst_pc;
        issue_en        = 1'b0;

        case (state)
            IDLE: begin
                inst_valid_nxt = 1'b0;
                skid_valid_nxt = 1'b0;
                // No read is issued in the start cycle; the first one follows.
                if (start) begin
                    pc_nxt    = start_pc;
                    state_nxt = FETCH;
                end
            end

            FETCH: begin
                if (halt) begin
                    // Halt outranks branch and leaves the PC where it stopped.
                    state_nxt      = IDLE;
                    inst_valid_nxt = 1'b0;
                    skid_valid_nxt = 1'b0;
                end else if (branch_valid) begin
                    // The word on mem_q belongs to the old path and is dropped.
                    pc_nxt         = branch_target;
                    inst_valid_nxt = 1'b0;
                    skid_valid_nxt = 1'b0;
                end else begin
                    // Never let a returning word find both output and skid full.
                    issue_en = !skid_valid && !(inflight && inst_valid && !inst_ready);

                    // Skid and in-flight are never both occupied: issue stops
                    // while the skid holds a word.
                    if (skid_valid) begin
                        if (out_free) begin
                            inst_nxt       = skid_inst;
                            inst_pc_nxt    = skid_pc;
                            inst_valid_nxt = 1'b1;
                            skid_valid_nxt = 1'b0;
                        end
                    end else if (inflight) begin
                        if (out_free) begin
                            inst_nxt       = mem_q;
                            inst_pc_nxt    = inflight_pc;
                            inst_valid_nxt = 1'b1;
                        end else begin
                            skid_inst_nxt  = mem_q;
                            skid_pc_nxt    = inflight_pc;
                            skid_valid_nxt = 1'b1;
                        end
                    end else if (out_free) begin
                        inst_valid_nxt = 1'b0;
                    end

                    if (issue_en) begin
                        inflight_nxt    = 1'b1;
                        inflight_pc_nxt = pc;
                        pc_nxt          = pc + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a queue-based model.

module tb_inst_fetch_ctrl;

    localparam int AW = 8;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_pc = '0;
    logic          halt = 1'b0;
    logic          branch_valid = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_q = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b1;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch_ctrl #(.ADDR_W(AW), .INST_W(IW), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .halt(halt), .branch_valid(branch_valid), .branch_target(branch_target),
        .mem_addr(mem_addr), .mem_q(mem_q), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] memf(logic [AW-1:0] a);
        return {a, ~a, a ^ 8'h5A, a + 8'd3};
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) mem_q <= memf(mem_addr);

    // Model: fetching flag, pc, one word in transit from memory, an ordered
    // list of returned-but-not-presented words, and the presented word.
    logic          m_busy = 1'b0;
    logic [AW-1:0] m_pc = '0;
    logic          m_tv = 1'b0;
    logic [AW-1:0] m_tpc = '0;
    logic [AW-1:0] m_pend[$];
    logic          m_ov = 1'b0;
    logic [AW-1:0] m_opc = '0;

    task automatic model_reset();
        m_busy = 1'b0; m_pc = '0; m_tv = 1'b0; m_pend.delete(); m_ov = 1'b0; m_opc = '0;
    endtask

    task automatic model_step();
        bit stalled, issue;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_pc   = start_pc;
            end
        end else if (halt || branch_valid) begin
            m_tv = 1'b0;
            m_pend.delete();
            m_ov = 1'b0;
            if (halt) m_busy = 1'b0;
            else      m_pc = branch_target;
        end else begin
            stalled = m_ov && !inst_ready;
            issue   = (m_pend.size() == 0) && !(m_tv && stalled);
            if (m_tv) m_pend.push_back(m_tpc);
            if (!stalled) begin
                if (m_pend.size() > 0) begin
                    m_ov  = 1'b1;
                    m_opc = m_pend.pop_front();
                end else begin
                    m_ov = 1'b0;
                end
            end
            m_tv  = issue;
            m_tpc = m_pc;
            if (issue) m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("valid", 32'(inst_valid), 32'(m_ov));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("mem_addr", 32'(mem_addr), 32'(m_pc));
        if (m_ov) begin
            chk("inst_pc", 32'(inst_pc), 32'(m_opc));
            chk("inst", inst, memf(m_opc));
        end
    endtask

    // One clock: model advances on the edge, outputs compared mid-cycle.
    // Inputs are changed by the caller right after this returns.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        // Reset state
        model_reset();
        repeat (3) cycle();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", 32'(inst_pc), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Stream from 0 with decode always ready
        inst_ready = 1'b1;
        start = 1'b1; start_pc = 8'h00;
        cycle();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("lat_e0", 32'(inst_valid), 32'd0);
        cycle();
        chk("lat_e1", 32'(inst_valid), 32'd0);
        cycle();
        chk("lat_e2", 32'(inst_valid), 32'd1);
        chk("first_pc", 32'(inst_pc), 32'd0);
        chk("first_inst", inst, memf(8'h00));
        cycle();
        chk("stream_pc1", 32'(inst_pc), 32'd1);
        cycle();
        chk("stream_pc2", 32'(inst_pc), 32'd2);

        // Backpressure for three cycles, then one bubble on recovery
        inst_ready = 1'b0;
        repeat (3) cycle();
        chk("stall_pc", 32'(inst_pc), 32'd2);
        chk("stall_inst", inst, memf(8'h02));
        inst_ready = 1'b1;
        cycle();
        chk("skid_pc", 32'(inst_pc), 32'd3);
        cycle();
        chk("bubble", 32'(inst_valid), 32'd0);
        cycle();
        chk("resume_pc", 32'(inst_pc), 32'd4);
        cycle();
        chk("pre_branch_pc", 32'(inst_pc), 32'd5);

        // Branch to 0x40 while 0x05 is presented
        branch_valid = 1'b1; branch_target = 8'h40;
        cycle();
        branch_valid = 1'b0;
        chk("br_flush0", 32'(inst_valid), 32'd0);
        cycle();
        chk("br_flush1", 32'(inst_valid), 32'd0);
        cycle();
        chk("br_valid", 32'(inst_valid), 32'd1);
        chk("br_pc", 32'(inst_pc), 32'h40);

        // Halt while stalled with the skid occupied
        inst_ready = 1'b0;
        repeat (3) cycle();
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        inst_ready = 1'b1;
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_valid", 32'(inst_valid), 32'd0);
        start = 1'b1; start_pc = 8'h10;
        cycle();
        start = 1'b0;
        repeat (2) cycle();
        chk("restart_pc", 32'(inst_pc), 32'h10);

        // PC wrap
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        start = 1'b1; start_pc = 8'hFE;
        cycle();
        start = 1'b0;
        repeat (2) cycle();
        chk("wrap_fe", 32'(inst_pc), 32'hFE);
        cycle();
        chk("wrap_ff", 32'(inst_pc), 32'hFF);
        cycle();
        chk("wrap_00", 32'(inst_pc), 32'h00);
        cycle();
        chk("wrap_01", 32'(inst_pc), 32'h01);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_inst", inst, 32'd0);
        chk("arst_inst_pc", 32'(inst_pc), 32'd0);
        cycle();
        rst_n = 1'b1;
        repeat (4) cycle();
        chk("post_rst_valid", 32'(inst_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            inst_ready    = ($urandom_range(0, 3) != 0);
            start         = ($urandom_range(0, 3) == 0);
            start_pc      = 8'($urandom);
            branch_valid  = ($urandom_range(0, 24) == 0);
            branch_target = 8'($urandom);
            halt          = ($urandom_range(0, 79) == 0);
            cycle();
        end
        start = 1'b0; halt = 1'b0; branch_valid = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
